// File: rtl/wb4_cmd_master.sv
// Wishbone B4 classic initiator: converts a valid/ready command stream into
// single read/write bus cycles and returns data plus status on a valid/ready
// response stream. A per-cycle timeout aborts the cycle if the slave never
// terminates it.
`timescale 1ns/1ps
module wb4_cmd_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_status,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    // Timer only needs to reach TIMEOUT-1; keep at least one bit when disabled.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUS_ERR = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t                  state_q;
    logic                    cmd_ready_q;
    logic                    cyc_q;
    logic                    stb_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [SEL_WIDTH-1:0]    sel_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              status_q;
    logic [TW-1:0]           timer_q;
    logic                    timeout_hit;

    // Last permitted STB cycle: the abort happens on the edge closing it, so
    // STB is high for exactly TIMEOUT cycles.
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT - 1));

    // Command/bus/response FSM; every output comes straight from a register.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            status_q    <= ST_OK;
            timer_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        we_q        <= cmd_we;
                        adr_q       <= cmd_addr;
                        dat_q       <= cmd_wdata;
                        sel_q       <= cmd_sel;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        cmd_ready_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= S_BUS;
                    end
                end
                S_BUS: begin
                    if (stb_q) begin
                        if (wb_err_i || wb_ack_i || timeout_hit) begin
                            cyc_q       <= 1'b0;
                            stb_q       <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else if (TIMEOUT != 0) begin
                            timer_q <= timer_q + 1'b1;
                        end
                        // ERR outranks ACK when a slave raises both.
                        if (wb_err_i) begin
                            rdata_q  <= '0;
                            status_q <= ST_BUS_ERR;
                        end else if (wb_ack_i) begin
                            rdata_q  <= we_q ? '0 : wb_dat_i;
                            status_q <= ST_OK;
                        end else if (timeout_hit) begin
                            rdata_q  <= '0;
                            status_q <= ST_TIMEOUT;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = we_q;
    assign wb_adr_o   = adr_q;
    assign wb_dat_o   = dat_q;
    assign wb_sel_o   = sel_q;

endmodule

// File: tb/tb_wb4_cmd_master.sv
// Directed bench for wb4_cmd_master: reset, write with wait states, zero-wait
// read, ERR priority, timeout with stray ACK, response backpressure and
// reset in the middle of a bus cycle. The slave side is driven directly.
`timescale 1ns/1ps
module tb_wb4_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    int checks   = 0;
    int failures = 0;

    wb4_cmd_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_status(rsp_status),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_dat_o  (wb_dat_o),
        .wb_sel_o  (wb_sel_o),
        .wb_dat_i  (wb_dat_i),
        .wb_ack_i  (wb_ack_i),
        .wb_err_i  (wb_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a command at a negedge and hold it until accepted; returns at
    // the negedge after the accepting posedge (first STB cycle).
    task automatic issue_cmd(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] sel);
        int n;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_sel   = sel;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait: cmd_ready=%b after %0d cycles, need 1", cmd_ready, n);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Consume the response that is present now.
    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid} !== 5'b0 ||
            wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0 ||
            rsp_rdata !== 32'h0 || rsp_status !== 2'b00) begin
            failures++;
            $display("FAIL reset_state: rdy/cyc/stb/we/rv=%b%b%b%b%b adr=%h dat=%h sel=%h rd=%h st=%b, need all 0",
                     cmd_ready, wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid, wb_adr_o, wb_dat_o, wb_sel_o, rsp_rdata, rsp_status);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: cmd_ready=%b cyc=%b, need 1 0", cmd_ready, wb_cyc_o);
        end
    endtask

    task automatic test_write();
        issue_cmd(1'b1, 32'h10, 32'h0000_1234, 4'hF);
        wb_dat_i = 32'hFFFF_FFFF;
        // Three STB cycles: two wait states, ACK in the third.
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b1 ||
                wb_adr_o !== 32'h10 || wb_dat_o !== 32'h1234 || wb_sel_o !== 4'hF ||
                cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL write_hold[%0d]: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h rdy=%b rv=%b, need 1 1 1 10 1234 f 0 0",
                         c, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, cmd_ready, rsp_valid);
            end
            if (c == 2) wb_ack_i = 1'b1;
            @(negedge clk);
        end
        wb_ack_i = 1'b0;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b1 ||
            rsp_status !== 2'b00 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL write_rsp: cyc=%b stb=%b rv=%b st=%b rd=%h, need 0 0 1 00 0",
                     wb_cyc_o, wb_stb_o, rsp_valid, rsp_status, rsp_rdata);
        end
        take_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL write_done: rv=%b rdy=%b, need 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_read();
        issue_cmd(1'b0, 32'h4, 32'h0, 4'hF);
        // Cycle 2 counting the accept cycle as 1: STB up, slave acks now.
        checks++;
        if (wb_stb_o !== 1'b1 || wb_we_o !== 1'b0 || wb_adr_o !== 32'h4) begin
            failures++;
            $display("FAIL read_stb: stb=%b we=%b adr=%h, need 1 0 4", wb_stb_o, wb_we_o, wb_adr_o);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        // Cycle 3: response visible.
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_status !== 2'b00 || wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL read_rsp: rv=%b rd=%h st=%b stb=%b, need 1 deadbeef 00 0",
                     rsp_valid, rsp_rdata, rsp_status, wb_stb_o);
        end
        take_rsp();
    endtask

    task automatic test_error();
        issue_cmd(1'b0, 32'h8, 32'h0, 4'h3);
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        wb_dat_i = 32'h1234_5678;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b01 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL error_prio: rv=%b st=%b rd=%h, need 1 01 0", rsp_valid, rsp_status, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_timeout();
        int stb_cycles;
        issue_cmd(1'b0, 32'hC, 32'h0, 4'hF);
        stb_cycles = 0;
        while (wb_stb_o === 1'b1 && stb_cycles < 40) begin
            stb_cycles++;
            @(negedge clk);
        end
        checks++;
        if (stb_cycles != 8) begin
            failures++;
            $display("FAIL timeout_len: stb high %0d cycles, need 8", stb_cycles);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_rdata !== 32'h0 || wb_cyc_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_rsp: rv=%b st=%b rd=%h cyc=%b, need 1 10 0 0",
                     rsp_valid, rsp_status, rsp_rdata, wb_cyc_o);
        end
        // Late ACK while the response waits must be ignored.
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hAAAA_5555;
        @(negedge clk);
        wb_ack_i = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_status !== 2'b10 || rsp_rdata !== 32'h0 || wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL stray_ack_resp: rv=%b st=%b rd=%h stb=%b, need 1 10 0 0",
                     rsp_valid, rsp_status, rsp_rdata, wb_stb_o);
        end
        take_rsp();
        // Stray ACK/ERR while idle.
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_dat_i = 32'h0;
        checks++;
        if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL stray_ack_idle: rv=%b cyc=%b rdy=%b, need 0 0 1", rsp_valid, wb_cyc_o, cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        issue_cmd(1'b1, 32'h18, 32'hCAFE_0001, 4'h1);
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        // Queue the next command while the response is held off.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h20;
        cmd_wdata = 32'h0;
        cmd_sel   = 4'hF;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_status !== 2'b00 || rsp_rdata !== 32'h0 ||
                cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0) begin
                failures++;
                $display("FAIL backpressure[%0d]: rv=%b st=%b rd=%h rdy=%b cyc=%b, need 1 00 0 0 0",
                         c, rsp_valid, rsp_status, rsp_rdata, cmd_ready, wb_cyc_o);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_stb_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_release: rv=%b rdy=%b stb=%b, need 0 1 0", rsp_valid, cmd_ready, wb_stb_o);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h20 || wb_we_o !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: stb=%b adr=%h we=%b rdy=%b, need 1 20 0 0",
                     wb_stb_o, wb_adr_o, wb_we_o, cmd_ready);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0BAD_F00D;
        @(negedge clk);
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D) begin
            failures++;
            $display("FAIL b2b_rsp: rv=%b rd=%h, need 1 0badf00d", rsp_valid, rsp_rdata);
        end
        take_rsp();
    endtask

    task automatic test_reset_midcycle();
        issue_cmd(1'b1, 32'h30, 32'h5555_AAAA, 4'hF);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: cyc=%b stb=%b rv=%b rdy=%b, need 0 0 0 0",
                     wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        wb_ack_i = 1'b1;
        repeat (3) @(negedge clk);
        wb_ack_i = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_discard: rv=%b cyc=%b rdy=%b, need 0 0 1", rsp_valid, wb_cyc_o, cmd_ready);
        end
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        wb_dat_i  = 32'h0;
        wb_ack_i  = 1'b0;
        wb_err_i  = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_error();
        test_timeout();
        test_back_to_back();
        test_reset_midcycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
